writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised RISC-V write-back stage with MEM/WB handshake, load formatting, late-load wait state and retired-instruction counter. It sits between the memory stage and the register file. It accepts one instruction per cycle from MEM, selects and formats the result, and drives a registered register-file write port that also serves as the WB forwarding source. Load data may return in the accept cycle or later; the stage back-pressures MEM until it arrives.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64 only.
- RA_W, 5: register address width.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_valid  in  1  MEM presents an instruction.
- wb_ready  out  1  stage can accept; combinational, equals (state==IDLE).
- m_reg_write  in  1  instruction writes rd.
- m_rd  in  RA_W  destination register.
- m_sel  in  2  result select: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- m_alu  in  XLEN  ALU result.
- m_pc4  in  XLEN  PC+4.
- m_imm  in  XLEN  immediate (LUI).
- m_funct3  in  3  load type.
- m_addr_lo  in  log2(XLEN/8)  low address bits of the load.
- flush  in  1  kill the in-flight and the incoming instruction.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  raw aligned memory word.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  RA_W  write address, registered.
- rf_wdata  out  XLEN  write data, registered.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: IDLE, WAIT. Reset state is IDLE.
- Accept occurs when m_valid && wb_ready && !flush.
- Non-load accept: the result is latched into rf_* at the next edge and the instruction retires. State stays IDLE.
- Load accept with dmem_rvalid high in the same cycle: formatted data is written at the next edge and the instruction retires. State stays IDLE.
- Load accept with dmem_rvalid low: rd, funct3 and addr_lo are captured into holding registers and the state moves to WAIT. wb_ready is 0 while in WAIT.
- In WAIT with dmem_rvalid high: write and retire at the next edge, then return to IDLE.
- Write rule: rf_we=1 only when reg_write=1 and rd!=0. Retirement (instret+1) happens whether or not a write occurs.
- Load formatting, where byte lane = addr_lo:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half at lane addr_lo[..1] (halfword aligned, addr_lo[0] ignored).
  - 010 LW: word. Sign-extended when XLEN=64; lane addr_lo[2].
  - 100 LBU and 101 LHU: zero-extend.
  - 110 LWU: zero-extend; XLEN=64 only.
  - 011 LD: full word; XLEN=64 only.
  - Any other code, or a 64-bit-only code with XLEN=32, is treated as LW.
- flush: in IDLE, the incoming instruction is ignored. In WAIT, the held load is dropped with no write and no retire, and the state returns to IDLE. Either way rf_we=0 at the next edge. A dmem_rvalid arriving in the flush cycle is ignored.
- dmem_rvalid in IDLE with no load being accepted is ignored.
- instret increments by 1 per retirement and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, instret=0, state=IDLE (so wb_ready=1).
- Latency from accept to rf_we is 1 cycle. From dmem_rvalid in WAIT to rf_we is 1 cycle.
- rf_we is a single-cycle pulse per retiring writer. It is 0 in every cycle with no retirement, and rf_waddr/rf_wdata hold their last values.
- Throughput is 1 instruction per cycle while loads return in the accept cycle.
- wb_ready deasserts in the cycle after a late-load accept and reasserts in the cycle after dmem_rvalid.
- Reset asserted mid-WAIT returns to IDLE immediately; the pending load is lost.

## Test plan
- Reset then back-to-back ALU ops: rd=5 with alu=0x1234, then rd=6 with alu=0xFFFF0000 → rf_we pulses on consecutive cycles, regs 5 and 6 written, instret=2.
- LB with rdata=0x80FF7F01, addr_lo=3 → wdata=0xFFFFFF80. LBU with addr_lo=3 → 0x00000080. LH with addr_lo=2 → 0xFFFF80FF. LHU with addr_lo=2 → 0x000080FF.
- Late load: accept LW rd=7 with dmem_rvalid=0 → wb_ready=0 for 3 cycles. Then rvalid with rdata=0xDEADBEEF → next cycle rf_we=1, waddr=7, wdata=0xDEADBEEF, and wb_ready returns to 1.
- Write to rd=0 with reg_write=1, alu=0x55 → rf_we stays 0, instret increments by 1.
- flush asserted in WAIT together with dmem_rvalid → no rf_we, instret unchanged, wb_ready=1 next cycle.
- XLEN=64 with CNT_W=4 and 16 retirements → instret wraps to 0. In the same run, LW with rdata word 0x80000000 at lane 0 → wdata=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// RISC-V write-back stage. It sits between the memory stage and the register
// file. Each cycle it can accept one instruction from MEM and select its
// result (ALU, formatted load data, PC+4 or immediate). The result goes to a
// registered register-file write port, which also acts as the WB forwarding
// source. Every completed instruction increments a retired-instruction
// counter.
//
// Load data may arrive in the accept cycle or later. If it arrives later, the
// load's rd, funct3 and low address bits are held, and the stage stays in
// WAIT until dmem_rvalid is seen.
//
// Handshake: an instruction moves from MEM into this stage on a rising edge
// where m_valid && wb_ready && !flush. wb_ready is purely combinational
// (state == IDLE), so MEM must hold its instruction while wb_ready is low.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   m_valid          MEM presents an instruction
//   wb_ready         stage can accept (state == IDLE)
//   m_reg_write/m_rd destination write enable / register
//   m_sel            result select: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
//   m_alu/m_pc4/m_imm  candidate results
//   m_funct3         load type
//   m_addr_lo        low address bits of the load (byte lane)
//   flush            kill the in-flight and the incoming instruction
//   dmem_rvalid      load data valid
//   dmem_rdata       raw aligned memory word
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   instret          retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m_valid,
    output logic                        wb_ready,
    input  logic                        m_reg_write,
    input  logic [RA_W-1:0]             m_rd,
    input  logic [1:0]                  m_sel,
    input  logic [XLEN-1:0]             m_alu,
    input  logic [XLEN-1:0]             m_pc4,
    input  logic [XLEN-1:0]             m_imm,
    input  logic [2:0]                  m_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   m_addr_lo,
    input  logic                        flush,
    input  logic                        dmem_rvalid,
    input  logic [XLEN-1:0]             dmem_rdata,
    output logic                        rf_we,
    output logic [RA_W-1:0]             rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [CNT_W-1:0]            instret
);

    localparam int AW = $clog2(XLEN/8);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_IMM  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RA_W-1:0]   hold_rd_q, hold_rd_d;
    logic [2:0]        hold_f3_q, hold_f3_d;
    logic [AW-1:0]     hold_lo_q, hold_lo_d;
    logic              hold_we_q, hold_we_d;

    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic              accept;
    logic              retire;
    logic              wr_en;
    logic [RA_W-1:0]   wr_addr;
    logic [XLEN-1:0]   wr_data;

    // Load formatter inputs: use the held values while waiting for late data.
    logic [2:0]        fmt_f3;
    logic [AW-1:0]     fmt_lo;
    logic [AW-1:0]     lane_h;
    logic [AW-1:0]     lane_w;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_w;
    logic [XLEN-1:0]   load_data;

    assign wb_ready = (state_q == ST_IDLE);
    assign accept   = m_valid && wb_ready && !flush;

    assign fmt_f3 = (state_q == ST_WAIT) ? hold_f3_q : m_funct3;
    assign fmt_lo = (state_q == ST_WAIT) ? hold_lo_q : m_addr_lo;

    // Halfword and word lanes are aligned by clearing the low lane bits. For
    // XLEN=32, lane_w is always 0, so the word is the whole memory word.
    assign lane_h = fmt_lo & ~AW'(1);
    assign lane_w = fmt_lo & ~AW'(3);

    always_comb begin
        ld_b      = 8'(dmem_rdata  >> {fmt_lo, 3'b000});
        ld_h      = 16'(dmem_rdata >> {lane_h, 3'b000});
        ld_w      = 32'(dmem_rdata >> {lane_w, 3'b000});
        load_data = XLEN'($signed(ld_w));          // LW, and every fallback
        case (fmt_f3)
            3'b000: load_data = XLEN'($signed(ld_b));
            3'b001: load_data = XLEN'($signed(ld_h));
            3'b100: load_data = XLEN'(ld_b);
            3'b101: load_data = XLEN'(ld_h);
            3'b110: if (XLEN == 64) load_data = XLEN'(ld_w);
            3'b011: if (XLEN == 64) load_data = dmem_rdata;
            default: ;
        endcase
    end

    // Next-state and write-port control.
    always_comb begin
        state_d   = state_q;
        hold_rd_d = hold_rd_q;
        hold_f3_d = hold_f3_q;
        hold_lo_d = hold_lo_q;
        hold_we_d = hold_we_q;
        retire    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = m_rd;
        wr_data   = load_data;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (m_sel == SEL_LOAD) begin
                        if (dmem_rvalid) begin
                            retire = 1'b1;
                            wr_en  = m_reg_write;
                        end else begin
                            hold_rd_d = m_rd;
                            hold_f3_d = m_funct3;
                            hold_lo_d = m_addr_lo;
                            hold_we_d = m_reg_write;
                            state_d   = ST_WAIT;
                        end
                    end else begin
                        retire = 1'b1;
                        wr_en  = m_reg_write;
                        case (m_sel)
                            SEL_ALU: wr_data = m_alu;
                            SEL_PC4: wr_data = m_pc4;
                            SEL_IMM: wr_data = m_imm;
                            default: wr_data = load_data;
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                wr_addr = hold_rd_q;
                // flush takes priority, so rvalid in the flush cycle is dropped
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (dmem_rvalid) begin
                    retire  = 1'b1;
                    wr_en   = hold_we_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // x0 is never written, but a write to it still retires.
    always_comb begin
        rf_we_d    = retire && wr_en && (wr_addr != '0);
        rf_waddr_d = rf_we_d ? wr_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? wr_data : rf_wdata_q;
        instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_rd_q  <= '0;
            hold_f3_q  <= '0;
            hold_lo_q  <= '0;
            hold_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_rd_q  <= hold_rd_d;
            hold_f3_q  <= hold_f3_d;
            hold_lo_q  <= hold_lo_d;
            hold_we_q  <= hold_we_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            instret_q  <= instret_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 32-bit DUT signals ----------------
  logic        m_valid, m_reg_write, flush, dmem_rvalid;
  logic        wb_ready, rf_we;
  logic [4:0]  m_rd, rf_waddr;
  logic [1:0]  m_sel, m_addr_lo;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu, m_pc4, m_imm, dmem_rdata, rf_wdata;
  logic [63:0] instret;

  // ---------------- 64-bit DUT signals (CNT_W=4) ----------------
  logic        b_valid, b_reg_write, b_flush, b_rvalid;
  logic        b_ready, b_we;
  logic [4:0]  b_rd, b_waddr;
  logic [1:0]  b_sel;
  logic [2:0]  b_funct3, b_addr_lo;
  logic [63:0] b_alu, b_pc4, b_imm, b_rdata, b_wdata;
  logic [3:0]  b_instret;

  writeback_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut32 (
    .clk(clk), .rst(rst), .m_valid(m_valid), .wb_ready(wb_ready),
    .m_reg_write(m_reg_write), .m_rd(m_rd), .m_sel(m_sel),
    .m_alu(m_alu), .m_pc4(m_pc4), .m_imm(m_imm), .m_funct3(m_funct3),
    .m_addr_lo(m_addr_lo), .flush(flush), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .instret(instret)
  );

  writeback_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .m_valid(b_valid), .wb_ready(b_ready),
    .m_reg_write(b_reg_write), .m_rd(b_rd), .m_sel(b_sel),
    .m_alu(b_alu), .m_pc4(b_pc4), .m_imm(b_imm), .m_funct3(b_funct3),
    .m_addr_lo(b_addr_lo), .flush(b_flush), .dmem_rvalid(b_rvalid),
    .dmem_rdata(b_rdata), .rf_we(b_we), .rf_waddr(b_waddr),
    .rf_wdata(b_wdata), .instret(b_instret)
  );

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];     // {waddr, wdata} for dut32
  logic [68:0] exp64_q[$];   // {waddr, wdata} for dut64
  int total = 0;
  int bad = 0;
  longint exp_instret = 0;
  logic [36:0] mon_e;
  logic [68:0] mon_e64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb32_write: got write rd=%0d data=0x%0h required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_e) begin
          bad++;
          $display("FAIL wb32_write: got rd=%0d data=0x%0h required rd=%0d data=0x%0h",
                   rf_waddr, rf_wdata, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_we) begin
      total++;
      if (exp64_q.size() == 0) begin
        bad++;
        $display("FAIL wb64_write: got write rd=%0d data=0x%0h required no write", b_waddr, b_wdata);
      end else begin
        mon_e64 = exp64_q.pop_front();
        if ({b_waddr, b_wdata} !== mon_e64) begin
          bad++;
          $display("FAIL wb64_write: got rd=%0d data=0x%0h required rd=%0d data=0x%0h",
                   b_waddr, b_wdata, mon_e64[68:64], mon_e64[63:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic op32(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                      input logic [31:0] val, input logic [2:0] f3, input logic [1:0] lo,
                      input logic rv, input logic [31:0] rdata);
    m_valid     = 1'b1;
    m_sel       = sel;
    m_reg_write = rw;
    m_rd        = rd;
    m_alu       = (sel == 2'b00) ? val : 32'hA1A1_A1A1;
    m_pc4       = (sel == 2'b10) ? val : 32'hB2B2_B2B2;
    m_imm       = (sel == 2'b11) ? val : 32'hC3C3_C3C3;
    m_funct3    = f3;
    m_addr_lo   = lo;
    dmem_rvalid = rv;
    dmem_rdata  = rdata;
    @(posedge clk); #1;
    m_valid     = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic op64(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                      input logic [63:0] val, input logic [2:0] f3, input logic [2:0] lo,
                      input logic rv, input logic [63:0] rdata);
    b_valid     = 1'b1;
    b_sel       = sel;
    b_reg_write = rw;
    b_rd        = rd;
    b_alu       = (sel == 2'b00) ? val : 64'hA1A1_A1A1_A1A1_A1A1;
    b_pc4       = (sel == 2'b10) ? val : 64'hB2B2_B2B2_B2B2_B2B2;
    b_imm       = (sel == 2'b11) ? val : 64'hC3C3_C3C3_C3C3_C3C3;
    b_funct3    = f3;
    b_addr_lo   = lo;
    b_rvalid    = rv;
    b_rdata     = rdata;
    @(posedge clk); #1;
    b_valid     = 1'b0;
    b_rvalid    = 1'b0;
  endtask

  task automatic push32(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic push64(input logic [4:0] rd, input logic [63:0] d);
    exp64_q.push_back({rd, d});
  endtask

  localparam logic [31:0] RD32 = 32'h80FF_7F01;
  localparam logic [63:0] RD64 = 64'h1234_5678_8000_0000;

  // ---------------- stimulus ----------------
  initial begin
    m_valid = 0; m_reg_write = 0; m_rd = 0; m_sel = 0; m_alu = 0; m_pc4 = 0;
    m_imm = 0; m_funct3 = 0; m_addr_lo = 0; flush = 0; dmem_rvalid = 0; dmem_rdata = 0;
    b_valid = 0; b_reg_write = 0; b_rd = 0; b_sel = 0; b_alu = 0; b_pc4 = 0;
    b_imm = 0; b_funct3 = 0; b_addr_lo = 0; b_flush = 0; b_rvalid = 0; b_rdata = 0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_waddr", 64'(rf_waddr), 64'd0);
    check("reset_wdata", 64'(rf_wdata), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_ready", 64'(wb_ready), 64'd1);
    check("reset64_instret", 64'(b_instret), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back ALU writes
    push32(5, 32'h0000_1234); op32(2'b00, 1, 5, 32'h0000_1234, 3'b000, 0, 0, 0); exp_instret++;
    push32(6, 32'hFFFF_0000); op32(2'b00, 1, 6, 32'hFFFF_0000, 3'b000, 0, 0, 0); exp_instret++;
    check("alu_rf_we_pulse", 64'(rf_we), 64'd1);
    check("alu_instret", instret, 64'(exp_instret));

    // PC+4 and IMM select
    push32(12, 32'h0000_0100); op32(2'b10, 1, 12, 32'h0000_0100, 3'b000, 0, 0, 0); exp_instret++;
    push32(13, 32'hABCD_E000); op32(2'b11, 1, 13, 32'hABCD_E000, 3'b000, 0, 0, 0); exp_instret++;

    // load formatting with data in the accept cycle (back to back)
    push32(1, 32'hFFFF_FF80); op32(2'b01, 1, 1, 0, 3'b000, 3, 1, RD32); exp_instret++;
    push32(2, 32'h0000_0080); op32(2'b01, 1, 2, 0, 3'b100, 3, 1, RD32); exp_instret++;
    push32(3, 32'hFFFF_80FF); op32(2'b01, 1, 3, 0, 3'b001, 2, 1, RD32); exp_instret++;
    push32(4, 32'h0000_80FF); op32(2'b01, 1, 4, 0, 3'b101, 2, 1, RD32); exp_instret++;
    push32(8, 32'h0000_0001); op32(2'b01, 1, 8, 0, 3'b000, 0, 1, RD32); exp_instret++;
    push32(9, 32'h0000_7F01); op32(2'b01, 1, 9, 0, 3'b001, 1, 1, RD32); exp_instret++;
    push32(10, RD32);         op32(2'b01, 1, 10, 0, 3'b010, 2, 1, RD32); exp_instret++;
    push32(11, RD32);         op32(2'b01, 1, 11, 0, 3'b111, 1, 1, RD32); exp_instret++;
    push32(14, RD32);         op32(2'b01, 1, 14, 0, 3'b011, 0, 1, RD32); exp_instret++;
    push32(15, RD32);         op32(2'b01, 1, 15, 0, 3'b110, 0, 1, RD32); exp_instret++;
    check("load_instret", instret, 64'(exp_instret));
    check("load_ready", 64'(wb_ready), 64'd1);

    // late load: ready low for three cycles, then data
    op32(2'b01, 1, 7, 0, 3'b010, 0, 0, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      check("late_ready_low", 64'(wb_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("late_no_retire_yet", instret, 64'(exp_instret));
    push32(7, 32'hDEAD_BEEF);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    exp_instret++;
    check("late_rf_we", 64'(rf_we), 64'd1);
    check("late_ready_back", 64'(wb_ready), 64'd1);
    check("late_instret", instret, 64'(exp_instret));

    // late LB keeps funct3/addr_lo while MEM inputs change
    op32(2'b01, 1, 16, 0, 3'b000, 3, 0, 0);
    m_funct3 = 3'b010; m_addr_lo = 0; m_rd = 20;
    push32(16, 32'hFFFF_FF80);
    dmem_rvalid = 1'b1; dmem_rdata = RD32;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    exp_instret++;
    check("late_lb_instret", instret, 64'(exp_instret));

    // rd=0 write: retires without writing; reg_write=0 likewise
    op32(2'b00, 1, 0, 32'h0000_0055, 3'b000, 0, 0, 0); exp_instret++;
    check("x0_no_we", 64'(rf_we), 64'd0);
    check("x0_instret", instret, 64'(exp_instret));
    op32(2'b00, 0, 9, 32'h0000_0077, 3'b000, 0, 0, 0); exp_instret++;
    check("nowrite_no_we", 64'(rf_we), 64'd0);
    check("nowrite_instret", instret, 64'(exp_instret));

    // stray rvalid in IDLE is ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("stray_rvalid_instret", instret, 64'(exp_instret));

    // flush in WAIT together with rvalid
    op32(2'b01, 1, 17, 0, 3'b010, 0, 0, 0);
    check("flushw_ready_low", 64'(wb_ready), 64'd0);
    flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    flush = 1'b0; dmem_rvalid = 1'b0;
    check("flushw_no_we", 64'(rf_we), 64'd0);
    check("flushw_ready", 64'(wb_ready), 64'd1);
    check("flushw_instret", instret, 64'(exp_instret));

    // flush in IDLE drops the incoming instruction
    m_valid = 1'b1; m_sel = 2'b00; m_reg_write = 1'b1; m_rd = 18; m_alu = 32'h99;
    flush = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; flush = 1'b0;
    check("flushi_no_we", 64'(rf_we), 64'd0);
    check("flushi_instret", instret, 64'(exp_instret));
    check("flushi_ready", 64'(wb_ready), 64'd1);

    // reset asserted mid-WAIT
    op32(2'b01, 1, 19, 0, 3'b010, 0, 0, 0);
    check("rstw_ready_low", 64'(wb_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rstw_ready", 64'(wb_ready), 64'd1);
    check("rstw_instret", instret, 64'd0);
    check("rstw_rf_we", 64'(rf_we), 64'd0);
    exp_instret = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("rstw_lost_load", instret, 64'(exp_instret));

    // ---------------- XLEN=64, CNT_W=4 ----------------
    check("b_reset_instret", 64'(b_instret), 64'd0);
    push64(1, 64'hFFFF_FFFF_8000_0000); op64(2'b01, 1, 1, 0, 3'b010, 0, 1, RD64);
    push64(2, 64'h0000_0000_1234_5678); op64(2'b01, 1, 2, 0, 3'b010, 4, 1, RD64);
    push64(3, RD64);                    op64(2'b01, 1, 3, 0, 3'b011, 0, 1, RD64);
    push64(4, 64'h0000_0000_8000_0000); op64(2'b01, 1, 4, 0, 3'b110, 0, 1, RD64);
    push64(5, 64'h0000_0000_0000_0012); op64(2'b01, 1, 5, 0, 3'b000, 7, 1, RD64);
    push64(6, 64'h0000_0000_0000_1234); op64(2'b01, 1, 6, 0, 3'b001, 7, 1, RD64);
    check("b_load_instret", 64'(b_instret), 64'd6);
    for (int i = 0; i < 9; i++) op64(2'b00, 1, 0, 64'(i), 3'b000, 0, 0, 0);
    check("b_instret_15", 64'(b_instret), 64'd15);
    push64(9, 64'hCAFE_0000_0000_BEEF); op64(2'b00, 1, 9, 64'hCAFE_0000_0000_BEEF, 3'b000, 0, 0, 0);
    check("b_instret_wrap", 64'(b_instret), 64'd0);

    // drain and report
    repeat (3) @(posedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp64_q_empty", 64'(exp64_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
